input_tile_memory: RTL and testbench

- Responder side of the input-tile fetch interface: holds 6x6 int8 input tiles and serves two tile reads per request cycle to the tile-fetch/Winograd-transform controller.
- Tiles are loaded from a narrow 32-bit host/DMA stream and packed into 512-bit words.
- Sits between the host loader and the input data controller; owns the input tile storage for all input channels.

---
 rtl/input_tile_memory.sv | 127 ++++++++++++
 tb/tb_input_tile_memory.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_tile_memory.sv
// Input tile storage: packs 32-bit load beats into 512-bit tile words
// and serves two independent tile reads per request cycle.
module input_tile_memory #(
    parameter int DEPTH = 255,
    parameter int BEATS = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         input_addr_i_1,
    input  logic [7:0]         input_addr_i_2,
    input  logic               input_request_i,
    output logic signed [511:0] input_data_o_1,
    output logic signed [511:0] input_data_o_2,
    output logic               input_valid_o,
    input  logic [7:0]         load_addr_i,
    input  logic [31:0]        load_data_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    output logic               load_done_o,
    output logic [7:0]         tiles_loaded_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [8:0] DEPTH_W   = 9'(DEPTH);
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    state_t       state;
    state_t       next_state;
    logic [511:0] mem [DEPTH];
    logic [287:0] asm_word;
    logic [7:0]   tile_addr;
    logic [3:0]   beat_cnt;
    logic [8:0]   beat_base;
    logic         accept;
    logic         commit;
    logic         tile_ok;
    logic         ok_1;
    logic         ok_2;

    // 8'hFF is the null address; anything past the array is also empty
    function automatic logic in_range(input logic [7:0] a);
        return ({1'b0, a} < DEPTH_W) && (a != 8'hFF);
    endfunction

    assign ok_1    = in_range(input_addr_i_1);
    assign ok_2    = in_range(input_addr_i_2);
    assign tile_ok = in_range(tile_addr);
    assign commit  = (state == COMMIT);

    // Beat k lands at bits [287-32k -: 32]
    assign beat_base = 9'd287 - {beat_cnt, 5'd0};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and load handshake
    always_comb begin
        next_state   = state;
        load_ready_o = (state != COMMIT);
        accept       = load_valid_i && load_ready_o;
        unique case (state)
            IDLE:    if (accept) next_state = FILL;
            FILL:    if (accept && beat_cnt == LAST_BEAT) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Beat assembly, commit pulse and tile counter
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_word       <= '0;
            tile_addr      <= '0;
            beat_cnt       <= '0;
            load_done_o    <= 1'b0;
            tiles_loaded_o <= '0;
        end else begin
            load_done_o <= 1'b0;
            if (accept) begin
                if (state == IDLE) begin
                    tile_addr          <= load_addr_i;
                    asm_word[287:256]  <= load_data_i;
                    beat_cnt           <= 4'd1;
                end else begin
                    asm_word[beat_base -: 32] <= load_data_i;
                    beat_cnt                  <= beat_cnt + 4'd1;
                end
            end
            if (commit) begin
                load_done_o <= 1'b1;
                beat_cnt    <= '0;
                if (tile_ok && tiles_loaded_o != 8'hFF)
                    tiles_loaded_o <= tiles_loaded_o + 8'd1;
            end
        end
    end

    // Tile array write; reads in the same cycle still see the old word
    always_ff @(posedge clk) begin
        if (!reset && commit && tile_ok)
            mem[tile_addr] <= {224'd0, asm_word};
    end

    // Dual-lane read with one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            input_valid_o  <= 1'b0;
            input_data_o_1 <= '0;
            input_data_o_2 <= '0;
        end else begin
            input_valid_o  <= input_request_i && (ok_1 || ok_2);
            input_data_o_1 <= (input_request_i && ok_1) ?
                              mem[input_addr_i_1] : '0;
            input_data_o_2 <= (input_request_i && ok_2) ?
                              mem[input_addr_i_2] : '0;
        end
    end

endmodule

// File: tb/tb_input_tile_memory.sv
// Directed bench for input_tile_memory: load, read, stall,
// collision and reset-abort scenarios.
module tb_input_tile_memory;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         a1;
    logic [7:0]         a2;
    logic               req;
    logic signed [511:0] d1;
    logic signed [511:0] d2;
    logic               vld;
    logic [7:0]         laddr;
    logic [31:0]        ldata;
    logic               lvalid;
    logic               lready;
    logic               ldone;
    logic [7:0]         cnt;

    int errors = 0;
    int checks = 0;

    input_tile_memory dut (
        .clk            (clk),
        .reset          (reset),
        .input_addr_i_1 (a1),
        .input_addr_i_2 (a2),
        .input_request_i(req),
        .input_data_o_1 (d1),
        .input_data_o_2 (d2),
        .input_valid_o  (vld),
        .load_addr_i    (laddr),
        .load_data_i    (ldata),
        .load_valid_i   (lvalid),
        .load_ready_o   (lready),
        .load_done_o    (ldone),
        .tiles_loaded_o (cnt)
    );

    always #5 clk = ~clk;

    // Element [r][c] = base + 6r + c, element idx at bits [(35-idx)*8 +: 8]
    function automatic logic [287:0] mk_tile(input int base);
        logic [287:0] w;
        w = '0;
        for (int idx = 0; idx < 36; idx++)
            w[(35 - idx) * 8 +: 8] = 8'(base + idx);
        return w;
    endfunction

    function automatic logic [31:0] beat(input logic [287:0] w, input int k);
        logic [287:0] s;
        s = w >> (256 - 32 * k);
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one tile; reports edges from first-beat edge to the done
    // pulse and how many sampled cycles had load_ready_o low.
    task automatic load_tile(input logic [7:0] a, input logic [287:0] w,
                             input int stall_at, input int stall_n,
                             output int lat, output int rdy_low);
        int n;
        lat = -1;
        rdy_low = 0;
        n = -1;
        for (int k = 0; k < 9; k++) begin
            laddr  = a;
            ldata  = beat(w, k);
            lvalid = 1'b1;
            tick();
            n++;
            if (ldone && lat < 0) lat = n;
            if (!lready) rdy_low++;
            if (k == stall_at) begin
                lvalid = 1'b0;
                ldata  = 32'hDEAD_BEEF;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    n++;
                    if (ldone && lat < 0) lat = n;
                    if (!lready) rdy_low++;
                end
            end
        end
        lvalid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n++;
            if (ldone && lat < 0) lat = n;
            if (!lready) rdy_low++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 1'b0; a1 = '0; a2 = '0;
        laddr = '0; ldata = '0; lvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (vld !== 1'b0 || d1 !== '0 || d2 !== '0) begin
            errors++;
            $display("FAIL reset_read got vld=%b d1=%h d2=%h exp 0",
                     vld, d1, d2);
        end
        checks++;
        if (lready !== 1'b1 || ldone !== 1'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_load got rdy=%b done=%b cnt=%0d exp 1/0/0",
                     lready, ldone, cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_first_load();
        int lat, rl;
        load_tile(8'd3, mk_tile(-18), -1, 0, lat, rl);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL done_latency got=%0d exp=9", lat);
        end
        checks++;
        if (rl !== 1) begin
            errors++;
            $display("FAIL ready_low_cycles got=%0d exp=1", rl);
        end
        checks++;
        if (cnt !== 8'd1) begin
            errors++;
            $display("FAIL count_first got=%0d exp=1", cnt);
        end
    endtask

    task automatic test_read_null();
        logic [511:0] got;
        req = 1'b1; a1 = 8'd3; a2 = 8'hFF;
        tick();
        req = 1'b0;
        got = d1;
        checks++;
        if (vld !== 1'b1) begin
            errors++;
            $display("FAIL null_valid got=%b exp=1", vld);
        end
        checks++;
        if (got[287:280] !== 8'hEE || got[7:0] !== 8'h11) begin
            errors++;
            $display("FAIL tile_bytes got=%h/%h exp=ee/11",
                     got[287:280], got[7:0]);
        end
        checks++;
        if (got[511:288] !== '0 || got[287:0] !== mk_tile(-18)) begin
            errors++;
            $display("FAIL tile_word got=%h exp=%h", got, mk_tile(-18));
        end
        checks++;
        if (d2 !== '0) begin
            errors++;
            $display("FAIL null_lane2 got=%h exp=0", d2);
        end
        tick();
        checks++;
        if (vld !== 1'b0 || d1 !== '0 || d2 !== '0) begin
            errors++;
            $display("FAIL idle_read got vld=%b d1=%h d2=%h exp 0",
                     vld, d1, d2);
        end
    endtask

    task automatic test_back_to_back();
        int lat, rl;
        for (int a = 0; a < 6; a++)
            load_tile(8'(a), mk_tile(10 * a + 1), -1, 0, lat, rl);
        checks++;
        if (cnt !== 8'd7) begin
            errors++;
            $display("FAIL count_six got=%0d exp=7", cnt);
        end
        for (int p = 0; p < 3; p++) begin
            req = 1'b1;
            a1 = 8'(2 * p);
            a2 = 8'(2 * p + 1);
            tick();
            checks++;
            if (vld !== 1'b1 ||
                d1 !== {224'd0, mk_tile(10 * (2 * p) + 1)} ||
                d2 !== {224'd0, mk_tile(10 * (2 * p + 1) + 1)}) begin
                errors++;
                $display("FAIL b2b_pair%0d got vld=%b d1=%h d2=%h",
                         p, vld, d1[287:0], d2[287:0]);
            end
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int lat, rl;
        load_tile(8'd6, mk_tile(-100), 4, 4, lat, rl);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL stall_latency got=%0d exp=13", lat);
        end
        req = 1'b1; a1 = 8'd6; a2 = 8'd6;
        tick();
        req = 1'b0;
        checks++;
        if (d1 !== {224'd0, mk_tile(-100)} || d2 !== d1) begin
            errors++;
            $display("FAIL stall_word got d1=%h d2=%h exp=%h",
                     d1[287:0], d2[287:0], mk_tile(-100));
        end
    endtask

    task automatic test_collision();
        int lat, rl;
        logic [511:0] old_w, new_w;
        old_w = {224'd0, mk_tile(50)};
        new_w = {224'd0, mk_tile(90)};
        load_tile(8'd7, mk_tile(50), -1, 0, lat, rl);
        for (int k = 0; k < 9; k++) begin
            laddr = 8'd7; ldata = beat(mk_tile(90), k); lvalid = 1'b1;
            tick();
        end
        lvalid = 1'b0;
        req = 1'b1; a1 = 8'd7; a2 = 8'd7;
        tick();
        checks++;
        if (ldone !== 1'b1 || d1 !== old_w || d2 !== old_w) begin
            errors++;
            $display("FAIL collide_old got done=%b d1=%h exp=%h",
                     ldone, d1[287:0], old_w[287:0]);
        end
        tick();
        req = 1'b0;
        checks++;
        if (d1 !== new_w || d2 !== new_w) begin
            errors++;
            $display("FAIL collide_new got d1=%h exp=%h",
                     d1[287:0], new_w[287:0]);
        end
        checks++;
        if (cnt !== 8'd10) begin
            errors++;
            $display("FAIL count_collide got=%0d exp=10", cnt);
        end
    endtask

    task automatic test_null_load();
        int lat, rl;
        load_tile(8'hFF, mk_tile(33), -1, 0, lat, rl);
        checks++;
        if (lat !== 9 || cnt !== 8'd10) begin
            errors++;
            $display("FAIL null_load got lat=%0d cnt=%0d exp 9/10", lat, cnt);
        end
    endtask

    task automatic test_reset_abort();
        int lat, rl;
        int seen;
        for (int k = 0; k < 5; k++) begin
            laddr = 8'd9; ldata = beat(mk_tile(70), k); lvalid = 1'b1;
            tick();
        end
        lvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen = 0;
        for (int s = 0; s < 12; s++) begin
            tick();
            if (ldone) seen++;
        end
        checks++;
        if (seen !== 0 || cnt !== 8'd0 || lready !== 1'b1) begin
            errors++;
            $display("FAIL abort got done=%0d cnt=%0d rdy=%b exp 0/0/1",
                     seen, cnt, lready);
        end
        load_tile(8'd9, mk_tile(-60), -1, 0, lat, rl);
        checks++;
        if (lat !== 9 || cnt !== 8'd1) begin
            errors++;
            $display("FAIL after_abort got lat=%0d cnt=%0d exp 9/1", lat, cnt);
        end
        req = 1'b1; a1 = 8'd9; a2 = 8'd0;
        tick();
        req = 1'b0;
        checks++;
        if (d1 !== {224'd0, mk_tile(-60)} ||
            d2 !== {224'd0, mk_tile(1)}) begin
            errors++;
            $display("FAIL after_abort_read got d1=%h d2=%h",
                     d1[287:0], d2[287:0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_read_null();
        test_back_to_back();
        test_stall();
        test_collision();
        test_null_load();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
